a_bus_cycle_ctrl: RTL

Bus-A access sequencer for the console core. It arbitrates Bus-A between the CPU and the DMA controller, and drives the registered address, data and strobes consumed by the Bus-A address decoder and its targets. Each access is timed in master-clock cycles from the decoder's `mem_speed` classification, so the FAST/SLOW/XSLOW/VAR (FastROM) access lengths are enforced in one place.

---
 rtl/a_bus_cycle_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/a_bus_cycle_ctrl.sv
// a_bus_cycle_ctrl -- Bus-A access sequencer.
//   Arbitrates Bus-A between DMA (priority) and CPU, latches the winner's
//   address/data, and times each access from the decoder's mem_speed class.
// Ports:
//   clk, reset            master clock, synchronous active-high reset
//   memsel                FastROM enable, selects MEM_VAR length
//   cpu_* / dma_*         requester handshakes (req, addr, write, wdata, ack)
//   a_addr, a_wdata       latched bus address / write data
//   a_read, a_write       registered strobes, high for cnt 2..len-1
//   mem_speed, a_rdata    decoder classification and read data
//   rdata                 captured read data (held until the next read)
//   busy, dma_owner       access in progress / current-or-last owner is DMA

package bus_pkg;
    typedef enum logic [1:0] {MEM_FAST, MEM_SLOW, MEM_XSLOW, MEM_VAR} mem_speed_type;
endpackage

module a_bus_cycle_ctrl
    import bus_pkg::*;
#(
    parameter int FAST_LEN  = 6,
    parameter int SLOW_LEN  = 8,
    parameter int XSLOW_LEN = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memsel,
    input  logic          cpu_req,
    input  logic [23:0]   cpu_addr,
    input  logic          cpu_write,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic [23:0]   dma_addr,
    input  logic          dma_write,
    input  logic [7:0]    dma_wdata,
    output logic          dma_ack,
    output logic [23:0]   a_addr,
    output logic [7:0]    a_wdata,
    output logic          a_read,
    output logic          a_write,
    input  mem_speed_type mem_speed,
    input  logic [7:0]    a_rdata,
    output logic [7:0]    rdata,
    output logic          busy,
    output logic          dma_owner
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [3:0] len_q, len_map, len_eff;
    logic       dir_q;
    logic       last, arb, grant_dma, grant_cpu;
    logic       strobe_next, ack_next;

    always_comb begin
        len_map = 4'(SLOW_LEN);
        case (mem_speed)
            MEM_FAST:  len_map = 4'(FAST_LEN);
            MEM_SLOW:  len_map = 4'(SLOW_LEN);
            MEM_XSLOW: len_map = 4'(XSLOW_LEN);
            MEM_VAR:   len_map = memsel ? 4'(FAST_LEN) : 4'(SLOW_LEN);
            default:   len_map = 4'(SLOW_LEN);
        endcase
    end

    // len_q is only loaded at the end of cnt=0, so that cycle uses the live decode.
    always_comb begin
        len_eff    = (cnt == 4'd0) ? len_map : len_q;
        last       = (state == ACCESS) && (cnt == len_eff - 4'd1);
        arb        = (state == IDLE) || last;
        grant_dma  = arb && dma_req;
        grant_cpu  = arb && !dma_req && cpu_req;
        state_next = state;
        cnt_next   = cnt + 4'd1;
        if (arb) begin
            cnt_next   = 4'd0;
            state_next = (grant_dma || grant_cpu) ? ACCESS : IDLE;
        end
        // Strobes/ack are registered, so decode against the cycle being entered.
        // Both only fire for cnt_next >= 2, by which point len_q is valid.
        strobe_next = !arb && (state == ACCESS) && (cnt_next >= 4'd2) &&
                      (cnt_next <= len_q - 4'd1);
        ack_next    = !arb && (state == ACCESS) && (cnt_next == len_q - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_addr    <= 24'h0;
            a_wdata   <= 8'h00;
            dir_q     <= 1'b0;
            dma_owner <= 1'b0;
            len_q     <= 4'(SLOW_LEN);
            a_read    <= 1'b0;
            a_write   <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            if (grant_dma) begin
                a_addr    <= dma_addr;
                a_wdata   <= dma_wdata;
                dir_q     <= dma_write;
                dma_owner <= 1'b1;
            end else if (grant_cpu) begin
                a_addr    <= cpu_addr;
                a_wdata   <= cpu_wdata;
                dir_q     <= cpu_write;
                dma_owner <= 1'b0;
            end
            if (state == ACCESS && cnt == 4'd0)
                len_q <= len_map;
            a_read  <= strobe_next && !dir_q;
            a_write <= strobe_next && dir_q;
            cpu_ack <= ack_next && !dma_owner;
            dma_ack <= ack_next && dma_owner;
            if (last && !dir_q)
                rdata <= a_rdata;
        end
    end

    assign busy = (state == ACCESS);

endmodule
